// File: rtl/render_scheduler_if.sv
// rtl/render_scheduler_if.sv - request, renderer and VGA write-port signals of the render scheduler
interface render_scheduler_if;
    logic       req_board;
    logic       winning_msg;
    logic       brd_start;
    logic       brd_done;
    logic [8:0] brd_x;
    logic [7:0] brd_y;
    logic       brd_colour;
    logic       brd_wren;
    logic       msg_start;
    logic       msg_done;
    logic [8:0] msg_x;
    logic [7:0] msg_y;
    logic       msg_colour;
    logic       msg_wren;
    logic [8:0] x;
    logic [7:0] y;
    logic       colour;
    logic       writeEn;
    logic       busy;
    logic       timeout_err;

    modport slave (
        input  req_board, winning_msg,
        input  brd_done, brd_x, brd_y, brd_colour, brd_wren,
        input  msg_done, msg_x, msg_y, msg_colour, msg_wren,
        output brd_start, msg_start,
        output x, y, colour, writeEn, busy, timeout_err
    );

    modport master (
        output req_board, winning_msg,
        output brd_done, brd_x, brd_y, brd_colour, brd_wren,
        output msg_done, msg_x, msg_y, msg_colour, msg_wren,
        input  brd_start, msg_start,
        input  x, y, colour, writeEn, busy, timeout_err
    );
endinterface

// File: rtl/render_scheduler.sv
// rtl/render_scheduler.sv - arbitrates the VGA write port between board and banner renderers
module render_scheduler #(
    parameter int unsigned HOLDOFF = 16,
    parameter int unsigned TIMEOUT = 200000
) (
    input  logic                 clk,
    input  logic                 reset,
    render_scheduler_if.slave    bus
);
    typedef enum logic [2:0] {
        IDLE, START_BRD, WAIT_BRD, START_MSG, WAIT_MSG, HOLD
    } state_t;

    localparam logic [15:0] HOLD_LAST = 16'(HOLDOFF - 1);
    localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        pend_brd_q, pend_brd_d;
    logic        pend_msg_q, pend_msg_d;
    logic        msg_prev_q, msg_prev_d;
    logic [15:0] hold_q, hold_d;
    logic [19:0] wdog_q, wdog_d;
    logic        timeout_err_q, timeout_err_d;
    logic        brd_start_q, brd_start_d;
    logic        msg_start_q, msg_start_d;
    logic        busy_q, busy_d;
    logic        msg_rise;

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        wdog_d        = wdog_q;
        timeout_err_d = timeout_err_q;
        msg_rise      = bus.winning_msg & ~msg_prev_q;
        msg_prev_d    = bus.winning_msg;

        case (state_q)
            IDLE: begin
                if (pend_brd_q)
                    state_d = START_BRD;
                else if (pend_msg_q && bus.winning_msg)
                    state_d = START_MSG;
            end
            START_BRD: begin
                state_d = WAIT_BRD;
                wdog_d  = '0;
            end
            START_MSG: begin
                state_d = WAIT_MSG;
                wdog_d  = '0;
            end
            WAIT_BRD, WAIT_MSG: begin
                if ((state_q == WAIT_BRD) ? bus.brd_done : bus.msg_done) begin
                    state_d = HOLD;
                    hold_d  = '0;
                end else if (wdog_q == WDOG_LAST) begin
                    state_d       = HOLD;
                    hold_d        = '0;
                    timeout_err_d = 1'b1;
                end else begin
                    wdog_d = wdog_q + 20'd1;
                end
            end
            HOLD: begin
                if (hold_q == HOLD_LAST)
                    state_d = IDLE;
                else
                    hold_d = hold_q + 16'd1;
            end
            default: state_d = IDLE;
        endcase

        // Leaving IDLE always consumes the board request first; a new pulse in that cycle re-arms it.
        pend_brd_d = bus.req_board | (pend_brd_q & (state_q != IDLE));

        // A board redraw wipes the banner, so a finished board render re-queues it while it is still wanted.
        if (!bus.winning_msg)
            pend_msg_d = 1'b0;
        else if (msg_rise || (state_q == WAIT_BRD && bus.brd_done))
            pend_msg_d = 1'b1;
        else if (state_q == IDLE && !pend_brd_q)
            pend_msg_d = 1'b0;
        else
            pend_msg_d = pend_msg_q;

        brd_start_d = (state_d == START_BRD);
        msg_start_d = (state_d == START_MSG);
        busy_d      = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            pend_brd_q    <= 1'b0;
            pend_msg_q    <= 1'b0;
            msg_prev_q    <= 1'b0;
            hold_q        <= '0;
            wdog_q        <= '0;
            timeout_err_q <= 1'b0;
            brd_start_q   <= 1'b0;
            msg_start_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pend_brd_q    <= pend_brd_d;
            pend_msg_q    <= pend_msg_d;
            msg_prev_q    <= msg_prev_d;
            hold_q        <= hold_d;
            wdog_q        <= wdog_d;
            timeout_err_q <= timeout_err_d;
            brd_start_q   <= brd_start_d;
            msg_start_q   <= msg_start_d;
            busy_q        <= busy_d;
        end
    end

    always_comb begin
        bus.x       = '0;
        bus.y       = '0;
        bus.colour  = 1'b0;
        bus.writeEn = 1'b0;
        if (state_q == WAIT_BRD) begin
            bus.x       = bus.brd_x;
            bus.y       = bus.brd_y;
            bus.colour  = bus.brd_colour;
            bus.writeEn = bus.brd_wren;
        end else if (state_q == WAIT_MSG) begin
            bus.x       = bus.msg_x;
            bus.y       = bus.msg_y;
            bus.colour  = bus.msg_colour;
            bus.writeEn = bus.msg_wren;
        end
    end

    assign bus.brd_start   = brd_start_q;
    assign bus.msg_start   = msg_start_q;
    assign bus.busy        = busy_q;
    assign bus.timeout_err = timeout_err_q;
endmodule

// File: tb/tb_render_scheduler.sv
// tb/tb_render_scheduler.sv - randomized and directed checks of render_scheduler against a job-level model
module tb_render_scheduler;
    localparam int HOLDOFF = 4;
    localparam int TIMEOUT = 100;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    render_scheduler_if bus_if();

    render_scheduler #(.HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    int tests_run = 0;
    int tests_failed = 0;

    // Model: a job is either being started, being rendered (waited counts its cycles) or finished;
    // after a job the port stays reserved for m_hold more cycles.
    bit m_active, m_start, m_msg, m_pend_brd, m_pend_msg, m_prev, m_terr;
    int m_waited, m_hold;
    int n_brd_start, n_msg_start;
    bit auto_done;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        bit wb, wmg;
        logic [18:0] port_exp;
        wb  = m_active && !m_start && !m_msg;
        wmg = m_active && !m_start && m_msg;
        if (wb)
            port_exp = {bus_if.brd_x, bus_if.brd_y, bus_if.brd_colour, bus_if.brd_wren};
        else if (wmg)
            port_exp = {bus_if.msg_x, bus_if.msg_y, bus_if.msg_colour, bus_if.msg_wren};
        else
            port_exp = '0;
        check_eq("busy", 32'(bus_if.busy), 32'(m_active || m_hold > 0));
        check_eq("brd_start", 32'(bus_if.brd_start), 32'(m_active && m_start && !m_msg));
        check_eq("msg_start", 32'(bus_if.msg_start), 32'(m_active && m_start && m_msg));
        check_eq("timeout_err", 32'(bus_if.timeout_err), 32'(m_terr));
        check_eq("vga_port", 32'({bus_if.x, bus_if.y, bus_if.colour, bus_if.writeEn}), 32'(port_exp));
        if (bus_if.brd_start) n_brd_start++;
        if (bus_if.msg_start) n_msg_start++;
    endtask

    task automatic model_update();
        bit idle, waiting, done_b, done_m, go_brd, go_msg, rb, wm;
        rb = bus_if.req_board;
        wm = bus_if.winning_msg;
        if (reset) begin
            m_active = 0; m_start = 0; m_msg = 0; m_pend_brd = 0; m_pend_msg = 0;
            m_prev = 0; m_terr = 0; m_waited = 0; m_hold = 0;
            return;
        end
        idle    = !m_active && m_hold == 0;
        waiting = m_active && !m_start;
        done_b  = waiting && !m_msg && bus_if.brd_done;
        done_m  = waiting && m_msg && bus_if.msg_done;
        go_brd  = idle && m_pend_brd;
        go_msg  = idle && !m_pend_brd && m_pend_msg && wm;
        m_pend_brd = rb || (m_pend_brd && !go_brd);
        if (!wm)                       m_pend_msg = 0;
        else if (!m_prev || done_b)    m_pend_msg = 1;
        else if (go_msg)               m_pend_msg = 0;
        m_prev = wm;
        if (go_brd || go_msg) begin
            m_active = 1; m_start = 1; m_msg = go_msg;
        end else if (m_active && m_start) begin
            m_start = 0; m_waited = 0;
        end else if (waiting) begin
            if (done_b || done_m) begin
                m_active = 0; m_hold = HOLDOFF;
            end else if (m_waited == TIMEOUT - 1) begin
                m_active = 0; m_hold = HOLDOFF; m_terr = 1;
            end else begin
                m_waited++;
            end
        end else if (m_hold > 0) begin
            m_hold--;
        end
    endtask

    task automatic drive(input bit rst, input bit rb, input bit wm, input bit bd, input bit md);
        bit bdv, mdv;
        bdv = bd;
        mdv = md;
        if (auto_done) begin
            bdv = m_active && !m_start && !m_msg && m_waited == 5;
            mdv = m_active && !m_start && m_msg && m_waited == 5;
        end
        reset                = rst;
        bus_if.req_board     = rb;
        bus_if.winning_msg   = wm;
        bus_if.brd_done      = bdv;
        bus_if.msg_done      = mdv;
        #1;
        check_outputs();
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic step(input bit rst, input bit rb, input bit wm, input bit bd, input bit md);
        drive(rst, rb, wm, bd, md);
        tick();
    endtask

    initial begin
        bit wm_r;
        bus_if.brd_x = '0; bus_if.brd_y = '0; bus_if.brd_colour = 0; bus_if.brd_wren = 0;
        bus_if.msg_x = '0; bus_if.msg_y = '0; bus_if.msg_colour = 0; bus_if.msg_wren = 0;
        auto_done = 0;
        reset = 1;
        bus_if.req_board = 0; bus_if.winning_msg = 0; bus_if.brd_done = 0; bus_if.msg_done = 0;
        @(posedge clk); model_update(); #1;
        step(1, 0, 0, 0, 0);

        drive(0, 0, 0, 0, 0);
        check_eq("reset_busy", 32'(bus_if.busy), 32'd0);
        check_eq("reset_writeEn", 32'(bus_if.writeEn), 32'd0);
        tick();
        repeat (5) step(0, 0, 0, 0, 0);

        // board redraw latency, pass-through and holdoff
        step(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_eq("brd_start_t1", 32'(bus_if.brd_start), 32'd0);
        tick();
        drive(0, 0, 0, 0, 0);
        check_eq("brd_start_t2", 32'(bus_if.brd_start), 32'd1);
        check_eq("busy_t2", 32'(bus_if.busy), 32'd1);
        tick();
        bus_if.brd_wren = 1; bus_if.brd_x = 9'd37;
        drive(0, 0, 0, 0, 0);
        check_eq("wren_pass", 32'(bus_if.writeEn), 32'd1);
        check_eq("x_pass", 32'(bus_if.x), 32'd37);
        tick();
        repeat (10) step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0);
        for (int i = 0; i < HOLDOFF; i++) begin
            drive(0, 0, 0, 0, 0);
            check_eq("hold_busy", 32'(bus_if.busy), 32'd1);
            tick();
        end
        drive(0, 0, 0, 0, 0);
        check_eq("idle_after_hold", 32'(bus_if.busy), 32'd0);
        check_eq("iso_idle_wren", 32'(bus_if.writeEn), 32'd0);
        tick();
        bus_if.brd_wren = 0;

        step(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        check_eq("stray_msg_done", 32'(bus_if.busy), 32'd0);
        tick();

        // priority and coalescing
        auto_done = 1; n_brd_start = 0; n_msg_start = 0;
        step(0, 1, 1, 0, 0);
        for (int i = 1; i <= 80; i++) step(0, (i == 4 || i == 6), 1, 0, 0);
        check_eq("coalesce_brd_starts", 32'(n_brd_start), 32'd2);
        check_eq("coalesce_msg_starts", 32'(n_msg_start), 32'd1);

        // banner restore, with board pixels present during the banner render
        bus_if.brd_wren = 1;
        n_brd_start = 0; n_msg_start = 0;
        step(0, 1, 1, 0, 0);
        for (int i = 1; i <= 40; i++) step(0, 0, 1, 0, 0);
        check_eq("restore_brd_starts", 32'(n_brd_start), 32'd1);
        check_eq("restore_msg_starts", 32'(n_msg_start), 32'd1);
        n_brd_start = 0; n_msg_start = 0;
        step(0, 1, 1, 0, 0);
        for (int i = 1; i <= 40; i++) step(0, 0, (i < 10), 0, 0);
        check_eq("withdrawn_brd_starts", 32'(n_brd_start), 32'd1);
        check_eq("withdrawn_msg_starts", 32'(n_msg_start), 32'd0);
        bus_if.brd_wren = 0;
        auto_done = 0;

        // watchdog abort
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        for (int i = 0; i < TIMEOUT; i++) step(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_eq("wdog_terr", 32'(bus_if.timeout_err), 32'd1);
        check_eq("wdog_hold_busy", 32'(bus_if.busy), 32'd1);
        tick();
        repeat (HOLDOFF - 1) step(0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        check_eq("wdog_idle", 32'(bus_if.busy), 32'd0);
        tick();
        auto_done = 1; n_brd_start = 0;
        step(0, 1, 0, 0, 0);
        repeat (20) step(0, 0, 0, 0, 0);
        check_eq("after_wdog_brd_starts", 32'(n_brd_start), 32'd1);
        check_eq("terr_sticky", 32'(bus_if.timeout_err), 32'd1);
        auto_done = 0;

        // reset in the middle of a board render with the banner queued
        step(0, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        step(1, 0, 0, 0, 0);
        n_brd_start = 0; n_msg_start = 0;
        drive(0, 0, 0, 0, 0);
        check_eq("midrst_busy", 32'(bus_if.busy), 32'd0);
        check_eq("midrst_terr", 32'(bus_if.timeout_err), 32'd0);
        tick();
        repeat (10) step(0, 0, 0, 0, 0);
        check_eq("midrst_no_starts", 32'(n_brd_start + n_msg_start), 32'd0);

        // randomized traffic: frequent completions, then rare ones to exercise the watchdog
        wm_r = 0;
        for (int i = 0; i < 4500; i++) begin
            int done_mod;
            done_mod = (i < 3000) ? 10 : 200;
            if ($urandom_range(24) == 0) wm_r = ~wm_r;
            bus_if.brd_x = 9'($urandom); bus_if.brd_y = 8'($urandom);
            bus_if.brd_colour = 1'($urandom); bus_if.brd_wren = 1'($urandom);
            bus_if.msg_x = 9'($urandom); bus_if.msg_y = 8'($urandom);
            bus_if.msg_colour = 1'($urandom); bus_if.msg_wren = 1'($urandom);
            step(($urandom_range(399) == 0), ($urandom_range(7) == 0), wm_r,
                 ($urandom_range(done_mod - 1) == 0), ($urandom_range(done_mod - 1) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
